// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, inst_mem and IF/ID signals.
// The stage uses the master modport and its environment uses the slave modport.
interface if_stage_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;

    modport master (
        input  stall_i, redirect_i, redirect_target_i, imem_rdata_i,
        output imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_target_i, imem_rdata_i,
        input  imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_inst_o, if_id_valid_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads inst_mem and loads the IF/ID register.
// Optional macro PERF_CNT_EN adds the fetch and bubble counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000000
) (
    input  logic         clk,
    input  logic         rst,
`ifdef PERF_CNT_EN
    output logic [31:0]  fetch_cnt_o,
    output logic [31:0]  bubble_cnt_o,
`endif
    if_stage_if.master   bus
);
    // if_id_valid_o marks a real instruction; there is no ready input. Downstream
    // back-pressure arrives as stall_i, which freezes the PC and IF/ID together,
    // and redirect_i overrides stall_i so a taken branch is never lost.
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic [31:0] if_id_inst_q, if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        load_normal;
    logic        load_bubble;

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        load_normal   = 1'b0;
        load_bubble   = 1'b0;
        if (bus.redirect_i) begin
            pc_d          = {bus.redirect_target_i[31:2], 2'b00};
            if_id_pc_d    = 32'h0;
            if_id_pc4_d   = 32'h0;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
            load_bubble   = 1'b1;
        end else if (bus.stall_i) begin
            load_bubble   = 1'b1;
        end else begin
            pc_d          = pc_q + 32'd4;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_q + 32'd4;
            if_id_inst_d  = bus.imem_rdata_i;
            if_id_valid_d = 1'b1;
            load_normal   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_inst_q  <= NOP_INST;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'd0, load_normal};
        bubble_cnt_d = bubble_cnt_q + {31'd0, load_bubble};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = load_normal ^ load_bubble;
`endif

    assign bus.imem_addr_o   = pc_q;
    assign bus.if_id_pc_o    = if_id_pc_q;
    assign bus.if_id_pc4_o   = if_id_pc4_q;
    assign bus.if_id_inst_o  = if_id_inst_q;
    assign bus.if_id_valid_o = if_id_valid_q;
endmodule
